dat_chunk_load_ctrl: RTL and testbench
======================================

Name: dat_chunk_load_ctrl

Overview:
Sequencer that loads one sparse chunk into the Dat_Chunk_Comb buffer. It accepts BUS_SIZE-wide beats (sparsemap plus packed nonzero bytes) from the fetch stream over a valid/ready handshake. It generates the buffer's wr_valid/wr_count write sequence, accumulates the chunk's nonzero count, and holds the buffer stable for the compute consumer until the consumer releases it. The buffer is single-banked, so load and consume never overlap.

Parameters:
MEM_SIZE, `MEM_SIZE, chunk size in elements (sparsemap bits).
BUS_SIZE, `BUS_SIZE, beat width in elements; MEM_SIZE must be an integer multiple of BUS_SIZE.
CYC_NUM (localparam), MEM_SIZE/BUS_SIZE, beats per chunk.
CNT_W (localparam), $clog2(MEM_SIZE+1), width of the nonzero count.

Ports:
clk_i  in  1  clock.
rst_i  in  1  reset; one clock, synchronous, active-low.
abort_i  in  1  discard the partial or held chunk and restart loading.
in_valid_i  in  1  beat valid.
in_ready_o  out  1  beat ready.
in_sparsemap_i  in  BUS_SIZE  beat sparsemap.
in_nonzero_data_i  in  BUS_SIZE x 8  beat nonzero bytes.
wr_valid_o  out  1  to buffer wr_valid_i.
wr_count_o  out  $clog2(CYC_NUM)  to buffer wr_count_i.
wr_sparsemap_o  out  BUS_SIZE  to buffer wr_sparsemap_i.
wr_nonzero_data_o  out  BUS_SIZE x 8  to buffer wr_nonzero_data_i.
chunk_valid_o  out  1  buffer holds a complete chunk.
chunk_ready_i  in  1  consumer releases the chunk.
chunk_nz_cnt_o  out  CNT_W  total set bits across the chunk's sparsemap.

Behaviour:
- Reset (rst_i=0 at a clock edge):
  - state becomes LOAD; beat counter and nz count clear.
  - All outputs read 0: in_ready_o, wr_valid_o, wr_count_o, wr_* data, chunk_valid_o, chunk_nz_cnt_o.
  - in_ready_o reads 0 while rst_i is low.
- States: LOAD, FLUSH, HOLD.
- LOAD:
  - in_ready_o = !abort_i.
  - Handshake = in_valid_i & in_ready_o.
  - On a handshake, at the next edge: the beat is registered onto wr_*, wr_valid_o=1, wr_count_o=beat counter, beat counter +1, nz count += popcount(in_sparsemap_i).
  - With no handshake, wr_valid_o=0 next cycle and the counters hold.
  - Handshake on beat CYC_NUM-1: beat counter wraps to 0 and the state goes to FLUSH.
- FLUSH (one cycle):
  - in_ready_o=0; the last write is being captured by the buffer.
  - Next state is HOLD.
- HOLD:
  - chunk_valid_o=1, in_ready_o=0, wr_valid_o=0.
  - chunk_nz_cnt_o stays stable.
  - When chunk_ready_i=1: next state is LOAD, chunk_valid_o=0, nz count clears, and in_ready_o may go to 1 on the following cycle.
- Latency: chunk_valid_o rises exactly 2 cycles after the handshake edge of the last beat. wr_* lags the handshake by 1 cycle (registered outputs, no combinational path from in_* to wr_*).
- chunk_nz_cnt_o is registered. It shows the running sum during LOAD and the final sum in HOLD. The maximum value is MEM_SIZE, with no overflow.
- abort_i (rst_i has priority over abort_i):
  - Any state goes to LOAD at the next edge; counters clear; chunk_valid_o=0; wr_valid_o=0.
  - A beat presented during abort is not accepted, because in_ready_o is 0.
  - A write already registered (wr_valid_o=1 in the abort cycle) still completes to the buffer. It is harmless because it will be overwritten.
- abort_i and chunk_ready_i together in HOLD: the abort path is taken; the result is identical to a release.
- chunk_ready_i outside HOLD is ignored.
- Stale buffer contents are never flagged valid: chunk_valid_o requires all CYC_NUM beats since the last reset, abort or release.
- Buffer reset wiring: the buffer's rst_i is active-high, so top level drives it with !rst_i.

Decomposition:
- Shared package: state enum (LOAD, FLUSH, HOLD), CYC_NUM and CNT_W derivation functions, and a popcount function of BUS_SIZE bits.
- One sub-module is natural: dat_chunk_popcnt, a combinational BUS_SIZE-bit popcount adder tree, so it can be reused by the compute side.
- Everything else stays flat.

Test Plan (MEM_SIZE=128, BUS_SIZE=32, CYC_NUM=4):
- Reset: hold rst_i=0 for 3 cycles with in_valid_i=1 -> in_ready_o, wr_valid_o, chunk_valid_o and chunk_nz_cnt_o are all 0; after release, in_ready_o=1.
- Back-to-back load: 4 consecutive beats with sparsemaps FFFFFFFF, 0000000F, 00000000, 80000001 -> wr_count_o is 0,1,2,3 on consecutive cycles with wr_valid_o=1; chunk_valid_o=1 two cycles after the 4th handshake; chunk_nz_cnt_o=38.
- Gapped input: in_valid_i toggles 1,0,0,1,1,0,1 -> wr_count_o advances only on handshakes (0,1,2,3); FLUSH then HOLD follow the 4th beat.
- Backpressure and release: hold 10 cycles in HOLD with in_valid_i=1 -> in_ready_o=0 and the count stays stable. Pulse chunk_ready_i -> next cycle chunk_valid_o=0, chunk_nz_cnt_o=0, in_ready_o=1, and the next beat writes wr_count_o=0.
- Abort: 2 beats loaded (nz=5), then abort_i for 1 cycle -> in_ready_o=0 in that cycle; the next 4 beats write counts 0..3 and the final nz counts only those 4 beats. Abort in HOLD drops chunk_valid_o the next cycle.
- Reset mid-load: rst_i=0 one cycle after beat 2 -> all outputs are 0; after release the load restarts at wr_count_o=0 and chunk_nz_cnt_o=0.

Source files
------------

// File: rtl/dat_chunk_load_ctrl_pkg.sv
// Shared definitions for the sparse-chunk load path.
//   state_e        : load sequencer states (LOAD, FLUSH, HOLD)
//   calc_cyc_num() : beats per chunk (MEM_SIZE / BUS_SIZE)
//   calc_cnt_w()   : width of a nonzero count that can reach MEM_SIZE
//   popcount()     : set-bit count; callers zero-extend their beat sparsemap
//                    into the POP_MAX_W-bit argument
package dat_chunk_load_ctrl_pkg;

  typedef enum logic [1:0] {
    LOAD,
    FLUSH,
    HOLD
  } state_e;

  localparam int unsigned POP_MAX_W = 1024;

  function automatic int unsigned calc_cyc_num(input int unsigned mem_size,
                                               input int unsigned bus_size);
    return mem_size / bus_size;
  endfunction

  function automatic int unsigned calc_cnt_w(input int unsigned mem_size);
    return $clog2(mem_size + 1);
  endfunction

  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] bits);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < POP_MAX_W; i++) begin
      n += {31'd0, bits[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/dat_chunk_popcnt.sv
// Combinational set-bit counter built as a balanced adder tree.
//   bits_i  : WIDTH-bit input vector
//   count_o : number of set bits in bits_i (0..WIDTH)
module dat_chunk_popcnt #(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned OUT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] bits_i,
  output logic [OUT_W-1:0] count_o
);

  // Leaves padded to a power of two; heap layout, node i = node 2i + node 2i+1,
  // root at index 1.
  localparam int unsigned LEAVES = (WIDTH > 1) ? (1 << $clog2(WIDTH)) : 1;

  logic [OUT_W-1:0] node [2*LEAVES];

  always_comb begin
    for (int unsigned i = 0; i < 2 * LEAVES; i++) begin
      node[i] = '0;
    end
    for (int unsigned i = 0; i < WIDTH; i++) begin
      node[LEAVES + i] = OUT_W'(bits_i[i]);
    end
    for (int unsigned i = LEAVES - 1; i >= 1; i--) begin
      node[i] = node[2*i] + node[2*i + 1];
    end
    count_o = node[1];
  end

endmodule

// File: rtl/dat_chunk_load_ctrl.sv
// Loads one sparse chunk into the single-banked Dat_Chunk_Comb buffer and holds
// it for the compute consumer until released. The buffer's reset is
// active-high, so the parent drives it with !rst_i.
//   clk_i, rst_i         : clock, synchronous active-low reset
//   abort_i              : drop partial/held chunk, restart loading
//   in_valid_i/ready_o   : beat handshake from the fetch stream
//   in_sparsemap_i       : beat sparsemap (BUS_SIZE bits)
//   in_nonzero_data_i    : beat packed nonzero bytes (BUS_SIZE x 8)
//   wr_valid_o/count_o   : registered buffer write strobe and beat index
//   wr_sparsemap_o       : registered beat sparsemap to the buffer
//   wr_nonzero_data_o    : registered beat data to the buffer
//   chunk_valid_o        : buffer holds a complete chunk
//   chunk_ready_i        : consumer releases the chunk
//   chunk_nz_cnt_o       : running / final set-bit total of the chunk
module dat_chunk_load_ctrl
  import dat_chunk_load_ctrl_pkg::*;
#(
  parameter  int unsigned MEM_SIZE = 128,
  parameter  int unsigned BUS_SIZE = 32,
  localparam int unsigned CYC_NUM  = calc_cyc_num(MEM_SIZE, BUS_SIZE),
  localparam int unsigned CNT_W    = calc_cnt_w(MEM_SIZE),
  localparam int unsigned BEAT_W   = (CYC_NUM > 1) ? $clog2(CYC_NUM) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  abort_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [BUS_SIZE-1:0]   in_sparsemap_i,
  input  logic [BUS_SIZE*8-1:0] in_nonzero_data_i,
  output logic                  wr_valid_o,
  output logic [BEAT_W-1:0]     wr_count_o,
  output logic [BUS_SIZE-1:0]   wr_sparsemap_o,
  output logic [BUS_SIZE*8-1:0] wr_nonzero_data_o,
  output logic                  chunk_valid_o,
  input  logic                  chunk_ready_i,
  output logic [CNT_W-1:0]      chunk_nz_cnt_o
);

  localparam int unsigned POP_W = $clog2(BUS_SIZE + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(CYC_NUM - 1);

  state_e                state_q, state_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [CNT_W-1:0]      nz_q, nz_d;
  logic                  wr_valid_q, wr_valid_d;
  logic [BEAT_W-1:0]     wr_count_q, wr_count_d;
  logic [BUS_SIZE-1:0]   wr_sm_q, wr_sm_d;
  logic [BUS_SIZE*8-1:0] wr_data_q, wr_data_d;
  logic [POP_W-1:0]      beat_pop;
  logic                  accept;

  dat_chunk_popcnt #(
    .WIDTH (BUS_SIZE)
  ) u_popcnt (
    .bits_i  (in_sparsemap_i),
    .count_o (beat_pop)
  );

  // Ready is gated by rst_i so nothing is accepted during the reset cycle.
  always_comb begin
    in_ready_o = rst_i && (state_q == LOAD) && !abort_i;
    accept     = in_valid_i && in_ready_o;
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    nz_d       = nz_q;
    wr_valid_d = 1'b0;
    wr_count_d = wr_count_q;
    wr_sm_d    = wr_sm_q;
    wr_data_d  = wr_data_q;

    if (abort_i) begin
      state_d = LOAD;
      beat_d  = '0;
      nz_d    = '0;
    end else begin
      unique case (state_q)
        LOAD: begin
          if (accept) begin
            wr_valid_d = 1'b1;
            wr_count_d = beat_q;
            wr_sm_d    = in_sparsemap_i;
            wr_data_d  = in_nonzero_data_i;
            nz_d       = nz_q + CNT_W'(beat_pop);
            if (beat_q == LAST_BEAT) begin
              beat_d  = '0;
              state_d = FLUSH;
            end else begin
              beat_d = beat_q + BEAT_W'(1);
            end
          end
        end
        // Lets the buffer capture the final write before the chunk is exposed.
        FLUSH: state_d = HOLD;
        HOLD: begin
          if (chunk_ready_i) begin
            state_d = LOAD;
            nz_d    = '0;
          end
        end
        default: state_d = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= LOAD;
      beat_q     <= '0;
      nz_q       <= '0;
      wr_valid_q <= 1'b0;
      wr_count_q <= '0;
      wr_sm_q    <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      nz_q       <= nz_d;
      wr_valid_q <= wr_valid_d;
      wr_count_q <= wr_count_d;
      wr_sm_q    <= wr_sm_d;
      wr_data_q  <= wr_data_d;
    end
  end

  always_comb begin
    wr_valid_o        = wr_valid_q;
    wr_count_o        = wr_count_q;
    wr_sparsemap_o    = wr_sm_q;
    wr_nonzero_data_o = wr_data_q;
    chunk_valid_o     = (state_q == HOLD);
    chunk_nz_cnt_o    = nz_q;
  end

endmodule

// File: tb/tb_dat_chunk_load_ctrl.sv
module tb_dat_chunk_load_ctrl;

  localparam int unsigned MEM_SIZE = 128;
  localparam int unsigned BUS_SIZE = 32;

  logic         clk;
  logic         rst;
  logic         abort;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_sm;
  logic [255:0] in_data;
  logic         wr_valid;
  logic [1:0]   wr_count;
  logic [31:0]  wr_sm;
  logic [255:0] wr_data;
  logic         chunk_valid;
  logic         chunk_ready;
  logic [7:0]   chunk_nz;

  dat_chunk_load_ctrl #(
    .MEM_SIZE (MEM_SIZE),
    .BUS_SIZE (BUS_SIZE)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .abort_i           (abort),
    .in_valid_i        (in_valid),
    .in_ready_o        (in_ready),
    .in_sparsemap_i    (in_sm),
    .in_nonzero_data_i (in_data),
    .wr_valid_o        (wr_valid),
    .wr_count_o        (wr_count),
    .wr_sparsemap_o    (wr_sm),
    .wr_nonzero_data_o (wr_data),
    .chunk_valid_o     (chunk_valid),
    .chunk_ready_i     (chunk_ready),
    .chunk_nz_cnt_o    (chunk_nz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   cnt;
    logic [31:0]  sm;
    logic [255:0] data;
  } wr_exp_t;

  wr_exp_t     wr_q[$];
  int unsigned nz_exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [1:0]  exp_cnt = 2'd0;
  logic [31:0] seed = 32'h1357_9BDF;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One beat that the DUT is expected to accept this cycle.
  task automatic beat(input logic [31:0] sm);
    logic [255:0] d;
    d        = {8{sm ^ seed}};
    seed     = seed + 32'h0102_0304;
    in_valid = 1'b1;
    in_sm    = sm;
    in_data  = d;
    @(negedge clk);
    check("in_ready_load", in_ready, 1);
    wr_q.push_back('{exp_cnt, sm, d});
    exp_cnt = exp_cnt + 2'd1;
    tick();
    in_valid = 1'b0;
  endtask

  // Monitor: every buffer write and every chunk completion is matched
  // against the expectations queued by the stimulus.
  wr_exp_t mon_e;
  logic    cv_prev = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (wr_valid === 1'b1) begin
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected: got wr_valid=1 count=%0d expected no write", wr_count);
        end else begin
          mon_e = wr_q.pop_front();
          check("wr_count", wr_count, mon_e.cnt);
          check("wr_sparsemap", wr_sm, mon_e.sm);
          check("wr_data", wr_data, mon_e.data);
        end
      end
      if (chunk_valid === 1'b1 && !cv_prev) begin
        if (nz_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL chunk_unexpected: got chunk_valid=1 nz=%0d expected none", chunk_nz);
        end else begin
          check("chunk_nz", chunk_nz, nz_exp_q.pop_front());
        end
      end
      cv_prev = (chunk_valid === 1'b1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b0; abort = 1'b0; in_valid = 1'b1; in_sm = '1; in_data = '1; chunk_ready = 1'b0;

    // Reset held with a beat presented
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_wr_valid", wr_valid, 0);
      check("rst_wr_count", wr_count, 0);
      check("rst_chunk_valid", chunk_valid, 0);
      check("rst_nz", chunk_nz, 0);
    end
    tick();
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    tick();

    // Back-to-back load: 32+4+0+2
    exp_cnt = 2'd0;
    nz_exp_q.push_back(38);
    beat(32'hFFFF_FFFF); beat(32'h0000_000F); beat(32'h0000_0000); beat(32'h8000_0001);
    @(negedge clk);
    check("flush_chunk_valid", chunk_valid, 0);
    check("flush_in_ready", in_ready, 0);
    check("flush_nz", chunk_nz, 38);
    tick();

    // HOLD with a beat waiting: no acceptance, stable count
    in_valid = 1'b1; in_sm = 32'hDEAD_BEEF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_chunk_valid", chunk_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_nz", chunk_nz, 38);
      tick();
    end
    in_valid = 1'b0; chunk_ready = 1'b1;
    tick();
    chunk_ready = 1'b0;
    @(negedge clk);
    check("rel_chunk_valid", chunk_valid, 0);
    check("rel_nz", chunk_nz, 0);
    check("rel_in_ready", in_ready, 1);
    tick();

    // Gapped input 1,0,0,1,1,0,1: 2+8+16+1
    exp_cnt = 2'd0;
    nz_exp_q.push_back(27);
    beat(32'h0000_0003); tick(); tick(); beat(32'h0000_00FF); beat(32'hF0F0_F0F0); tick(); beat(32'h0000_0001);
    @(negedge clk);
    check("gap_flush_valid", chunk_valid, 0);
    tick();
    @(negedge clk);
    check("gap_hold_valid", chunk_valid, 1);
    check("gap_hold_nz", chunk_nz, 27);
    tick();
    chunk_ready = 1'b1;
    tick();
    chunk_ready = 1'b0;

    // Abort after two beats (nz=5), beat presented during abort is refused
    exp_cnt = 2'd0;
    beat(32'h0000_0007); beat(32'h0000_0011);
    abort = 1'b1; in_valid = 1'b1; in_sm = 32'hFFFF_FFFF;
    @(negedge clk);
    check("abort_in_ready", in_ready, 0);
    check("abort_pre_nz", chunk_nz, 5);
    tick();
    abort = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("abort_nz", chunk_nz, 0);
    check("abort_chunk_valid", chunk_valid, 0);
    tick();
    exp_cnt = 2'd0;
    nz_exp_q.push_back(57);
    beat(32'h0000_0100); beat(32'h0000_FFFF); beat(32'h00FF_0000); beat(32'hFFFF_FFFF);
    tick();
    @(negedge clk);
    check("abort_reload_valid", chunk_valid, 1);
    check("abort_reload_nz", chunk_nz, 57);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("abort_hold_valid", chunk_valid, 0);
    check("abort_hold_nz", chunk_nz, 0);
    check("abort_hold_in_ready", in_ready, 1);
    tick();

    // Reset in the cycle after beat 2
    exp_cnt = 2'd0;
    beat(32'h0000_0001); beat(32'h0000_0003);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_wr_valid", wr_valid, 0);
    check("midrst_wr_count", wr_count, 0);
    check("midrst_wr_sm", wr_sm, 0);
    check("midrst_wr_data", wr_data, 0);
    check("midrst_chunk_valid", chunk_valid, 0);
    check("midrst_nz", chunk_nz, 0);
    check("midrst_in_ready", in_ready, 1);
    tick();

    // Full chunk (max count 128) with chunk_ready asserted outside HOLD
    exp_cnt = 2'd0;
    nz_exp_q.push_back(128);
    chunk_ready = 1'b1;
    beat(32'hFFFF_FFFF); beat(32'hFFFF_FFFF); beat(32'hFFFF_FFFF); beat(32'hFFFF_FFFF);
    tick();
    chunk_ready = 1'b0;
    @(negedge clk);
    check("max_hold_valid", chunk_valid, 1);
    check("max_hold_nz", chunk_nz, 128);
    tick();

    // Abort and release together in HOLD
    abort = 1'b1; chunk_ready = 1'b1;
    tick();
    abort = 1'b0; chunk_ready = 1'b0;
    @(negedge clk);
    check("abort_rel_valid", chunk_valid, 0);
    check("abort_rel_nz", chunk_nz, 0);
    check("abort_rel_in_ready", in_ready, 1);

    repeat (3) tick();
    check("wr_queue_drained", wr_q.size(), 0);
    check("chunk_queue_drained", nz_exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
